// File: rtl/bcd_pkg.sv
// Shared types and helpers for the decimal arithmetic datapath.
package bcd_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic nibble_invalid(input logic [BCD_W-1:0] n);
      return (n > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor with borrow: d = x - y - bin, corrected into 0..9.
module bcd_digit_sub (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [4:0] t;

   always_comb begin
      t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
      bout = t[4];
      // wraps modulo 16, so a raw -10 lands on 0 as required
      d    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
   end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor A - B, LSD first, one digit per clock.
// Define BCD_SUB_MAGNITUDE_EN to add a tens-complement FIX pass yielding |A-B|.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SUB   | subtract digit idx of a_q and b_q into diff_q
// FIX   | negate diff_q digit idx (magnitude build only)
// DONE  | result complete, done registered out next cycle
module bcd_serial_sub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [BCD_W*DIGITS-1:0]   a,
   input  logic [BCD_W*DIGITS-1:0]   b,
   output logic                      busy,
   output logic                      done,
   output logic [BCD_W*DIGITS-1:0]   diff,
   output logic                      neg,
   output logic                      invalid
);

   localparam int W     = BCD_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               borrow_q, borrow_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       diff_q, diff_d;
   logic               neg_q, neg_d;
   logic               invalid_q, invalid_d;
   logic               done_q, done_d;

   logic [3:0]         dx, dy, dd;
   logic               dbout;
   logic               any_bad;
   logic               last_digit;

   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         any_bad = any_bad | nibble_invalid(a[i*BCD_W +: BCD_W])
                           | nibble_invalid(b[i*BCD_W +: BCD_W]);
      end
   end

   assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

   // One digit slice serves both passes; FIX computes 0 - diff_i - borrow.
   always_comb begin
      dx = a_q[idx_q*BCD_W +: BCD_W];
      dy = b_q[idx_q*BCD_W +: BCD_W];
      if (state_q == FIX) begin
         dx = 4'd0;
         dy = diff_q[idx_q*BCD_W +: BCD_W];
      end
   end

   bcd_digit_sub u_digit (
      .x    (dx),
      .y    (dy),
      .bin  (borrow_q),
      .d    (dd),
      .bout (dbout)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      borrow_d  = borrow_q;
      a_d       = a_q;
      b_d       = b_q;
      diff_d    = diff_q;
      neg_d     = neg_q;
      invalid_d = invalid_q;
      done_d    = (state_q == DONE);

      case (state_q)
         IDLE: begin
            // done_q high means we just left DONE; that start is dropped
            if (start && !done_q) begin
               a_d      = a;
               b_d      = b;
               idx_d    = '0;
               borrow_d = 1'b0;
               diff_d   = '0;
               neg_d    = 1'b0;
               if (any_bad) begin
                  invalid_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  invalid_d = 1'b0;
                  state_d   = SUB;
               end
            end
         end
         SUB: begin
            diff_d[idx_q*BCD_W +: BCD_W] = dd;
            borrow_d = dbout;
            idx_d    = idx_q + 1'b1;
            if (last_digit) begin
               neg_d = dbout;
               idx_d = '0;
`ifdef BCD_SUB_MAGNITUDE_EN
               if (dbout) begin
                  borrow_d = 1'b0;
                  state_d  = FIX;
               end else begin
                  state_d  = DONE;
               end
`else
               state_d = DONE;
`endif
            end
         end
         FIX: begin
            diff_d[idx_q*BCD_W +: BCD_W] = dd;
            borrow_d = dbout;
            idx_d    = idx_q + 1'b1;
            if (last_digit) begin
               idx_d    = '0;
               borrow_d = 1'b0;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         borrow_q  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         diff_q    <= '0;
         neg_q     <= 1'b0;
         invalid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         borrow_q  <= borrow_d;
         a_q       <= a_d;
         b_q       <= b_d;
         diff_q    <= diff_d;
         neg_q     <= neg_d;
         invalid_q <= invalid_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q != IDLE) | done_q;
   assign done    = done_q;
   assign diff    = diff_q;
   assign neg     = neg_q;
   assign invalid = invalid_q;

endmodule
